genius_round_ctrl: RTL and testbench
====================================

// Module: genius_round_ctrl
// PURPOSE
//  Game-sequencing FSM for the Genius (Simon) game. It grows a random 3-colour sequence one entry per level.
//  It replays the sequence on LEDs, then checks the player's button presses against it.
//  It drives the debug buses State/Next_state/Current_level/Sequence_count/Current_number consumed by the top level.
// PARAMETERS
//  MAX_LEVEL       15   sequence length that wins the game (1..15)
//  SHOW_CYCLES     25e6 clocks each colour stays lit
//  GAP_CYCLES      12e6 clocks dark between colours
//  TIMEOUT_CYCLES  250e6 clocks allowed per player press (TIMEOUT_EN only)
// PORTS
//  clock           in   1  system clock; all logic rising-edge
//  reset           in   1  synchronous, active-high
//  start           in   1  level input; a rising edge starts or restarts a game
//  btn             in   3  debounced player buttons, level; rising edges are used
//  sw              in   8  LFSR seed, sampled on the start edge (sw[9:2] at top)
//  led_colour      out  3  one-hot colour being shown (bit i = colour i)
//  win             out  1  high while in WIN
//  lose            out  1  high while in LOSE
//  State           out  3  current state encoding
//  Next_state      out  3  combinational next state
//  Current_level   out  4  current sequence length
//  Sequence_count  out  4  index being shown or checked
//  Current_number  out  4  {2'b0, colour} at index Sequence_count
// BEHAVIOUR
//  - Clock and reset are fixed: one clock, `clock`; `reset` is synchronous and active-high.
//  - Reset: State=IDLE, all counters 0, LFSR=8'hA5, led_colour=0, win=0, lose=0. Reset mid-game aborts immediately.
//  - Edge detect: start_q and btn_q are registered. start_rise=start&~start_q; btn_rise=btn&~btn_q.
//  - States: IDLE=0, ADD=1, SHOW_ON=2, SHOW_OFF=3, WAIT_IN=4, CHECK=5, WIN=6, LOSE=7.
//  - IDLE/WIN/LOSE, start_rise: load LFSR with sw (8'hA5 if sw==0), Current_level=0 -> ADD.
//  - ADD: mem[Current_level] <= colour(LFSR); LFSR advances once; Current_level++; Sequence_count=0 -> SHOW_ON.
//  - SHOW_ON: led_colour=onehot(mem[Sequence_count]) for SHOW_CYCLES clocks -> SHOW_OFF.
//  - SHOW_OFF: LEDs dark for GAP_CYCLES clocks.
//      - If Sequence_count+1==Current_level: Sequence_count=0 -> WAIT_IN.
//      - Else: Sequence_count++ -> SHOW_ON.
//  - WAIT_IN: exactly one btn_rise bit set: latch its index -> CHECK.
//      - More than one bit set in the same cycle -> LOSE.
//      - No edge: stay.
//  - CHECK (1 cycle), on match:
//      - Last index and Current_level==MAX_LEVEL -> WIN.
//      - Last index otherwise -> ADD.
//      - Else Sequence_count++ -> WAIT_IN.
//  - CHECK, on mismatch: -> LOSE.
//  - Button edges outside WAIT_IN are ignored. start_rise outside IDLE/WIN/LOSE is ignored.
//  - LFSR: 8-bit, shift left, fb=q[7]^q[5]^q[4]^q[3].
//  - colour(LFSR) = (q[1:0]==3) ? 0 : q[1:0].
//  - Sequence memory: 16x2 register array; it is not cleared by reset.
//  - Latency: start_rise in cycle N -> ADD at N+1 -> first LED lit at N+2.
// CONFIGURATION
//  - TIMEOUT_EN defined: a per-press counter runs in WAIT_IN and reloads on entering WAIT_IN.
//      - Reaching TIMEOUT_CYCLES -> LOSE.
//      - A btn_rise on the same cycle as timeout wins (goes to CHECK).
//  - TIMEOUT_EN undefined: WAIT_IN waits indefinitely; no timeout counter is synthesised.
// STRUCTURE
//  - genius_pkg:
//      - state encodings (3-bit localparams/enum)
//      - LFSR_RESET=8'hA5
//      - COLOURS=3
//      - onehot function
//  - Sub-module genius_lfsr: load, advance, seed[7:0] -> q[7:0], colour[1:0].
//  - Timer: one shared down-counter, width $clog2 of the largest cycle parameter.
// TESTING (SHOW_CYCLES=2, GAP_CYCLES=1, MAX_LEVEL=3, TIMEOUT_CYCLES=20)
//  1. reset held 2 cycles with start=1 -> State=0, LEDs 0; no game starts without a fresh start edge.
//  2. sw=8'h01, start 0->1 -> sequence 1,2,0 generated.
//      - Level 1 shows led_colour=3'b010 for 2 cycles, starting 2 cycles after the edge.
//  3. Correct presses btn1; btn1,btn2; btn1,btn2,btn0 -> Current_level 1->2->3, then WIN with win=1.
//  4. Level 2, press btn0 where btn2 is expected -> CHECK then LOSE, lose=1.
//      - Next start edge -> ADD with Current_level=1.
//  5. btn pressed during SHOW_ON -> ignored.
//      - btn0 and btn1 rising together in WAIT_IN -> LOSE.
//  6. TIMEOUT_EN: no press for 20 cycles in WAIT_IN -> LOSE.
//      - Without the macro -> still WAIT_IN after 100 cycles.
//      - Reset asserted during SHOW_ON -> IDLE next cycle, LEDs 0.

Source files
------------

// File: rtl/genius_pkg.sv
// Shared types and helpers for the Genius (Simon) round controller.
package genius_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADD      = 3'd1,
    S_SHOW_ON  = 3'd2,
    S_SHOW_OFF = 3'd3,
    S_WAIT_IN  = 3'd4,
    S_CHECK    = 3'd5,
    S_WIN      = 3'd6,
    S_LOSE     = 3'd7
  } state_e;

  localparam logic [7:0] LFSR_RESET = 8'hA5;
  localparam int         COLOURS    = 3;

  function automatic logic [COLOURS-1:0] onehot(input logic [1:0] c);
    return COLOURS'(1) << c;
  endfunction

  // Index of the lowest set button bit; callers ensure exactly one is set.
  function automatic logic [1:0] btn_index(input logic [COLOURS-1:0] b);
    if (b[0])      return 2'd0;
    else if (b[1]) return 2'd1;
    else           return 2'd2;
  endfunction

endpackage

// File: rtl/genius_lfsr.sv
// 8-bit Fibonacci LFSR (taps 7,5,4,3) producing a 3-way colour per step.
module genius_lfsr
  import genius_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       advance,
  input  logic [7:0] seed,
  output logic [7:0] q,
  output logic [1:0] colour
);

  logic [7:0] q_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      q_q <= LFSR_RESET;
    end else if (load) begin
      // An all-zero seed would lock the LFSR up.
      q_q <= (seed == 8'h00) ? LFSR_RESET : seed;
    end else if (advance) begin
      q_q <= {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
    end
  end

  assign q      = q_q;
  assign colour = (q_q[1:0] == 2'b11) ? 2'b00 : q_q[1:0];

endmodule

// File: rtl/genius_round_ctrl.sv
// Genius/Simon round sequencer: grows, shows and checks a colour sequence.
// Optional macro TIMEOUT_EN adds a per-press timeout in WAIT_IN.
module genius_round_ctrl
  import genius_pkg::*;
#(
  parameter int MAX_LEVEL      = 15,
  parameter int SHOW_CYCLES    = 25_000_000,
  parameter int GAP_CYCLES     = 12_000_000,
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   btn,
  input  logic [7:0]   sw,
  output logic [2:0]   led_colour,
  output logic         win,
  output logic         lose,
  output logic [2:0]   State,
  output logic [2:0]   Next_state,
  output logic [3:0]   Current_level,
  output logic [3:0]   Sequence_count,
  output logic [3:0]   Current_number
);

  localparam int MAX_SG = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int MAXC   = (MAX_SG > TIMEOUT_CYCLES) ? MAX_SG : TIMEOUT_CYCLES;
  localparam int TW     = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);
  localparam logic [TW-1:0] SHOW_LOAD = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
`ifdef TIMEOUT_EN
  localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT_CYCLES - 1);
`endif

  state_e          state_q, state_d;
  logic [3:0]      level_q, level_d;
  logic [3:0]      seq_q, seq_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [1:0]      pick_q, pick_d;
  logic            start_q;
  logic [2:0]      btn_q;
  logic [1:0]      mem [16];
  logic            mem_we, lfsr_load, lfsr_adv;
  logic [7:0]      lfsr_state_unused;
  logic [1:0]      lfsr_colour;

  logic            start_rise;
  logic [2:0]      btn_rise;
  logic            btn_single;
  logic            last_idx;
  logic [1:0]      cur_colour;

  assign start_rise = start & ~start_q;
  assign btn_rise   = btn & ~btn_q;
  assign btn_single = (btn_rise != 3'b000) && ((btn_rise & (btn_rise - 3'd1)) == 3'b000);
  assign last_idx   = ((seq_q + 4'd1) == level_q);
  assign cur_colour = mem[seq_q];

  genius_lfsr u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .seed    (sw),
    .q       (lfsr_state_unused),
    .colour  (lfsr_colour)
  );

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    seq_d     = seq_q;
    timer_d   = timer_q;
    pick_d    = pick_q;
    mem_we    = 1'b0;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start_rise) begin
          lfsr_load = 1'b1;
          level_d   = 4'd0;
          state_d   = S_ADD;
        end
      end
      S_ADD: begin
        mem_we   = 1'b1;
        lfsr_adv = 1'b1;
        level_d  = level_q + 4'd1;
        seq_d    = 4'd0;
        timer_d  = SHOW_LOAD;
        state_d  = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (timer_q == '0) begin
          timer_d = GAP_LOAD;
          state_d = S_SHOW_OFF;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_SHOW_OFF: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else if (last_idx) begin
          seq_d   = 4'd0;
`ifdef TIMEOUT_EN
          timer_d = TO_LOAD;
`endif
          state_d = S_WAIT_IN;
        end else begin
          seq_d   = seq_q + 4'd1;
          timer_d = SHOW_LOAD;
          state_d = S_SHOW_ON;
        end
      end
      S_WAIT_IN: begin
        // A press on the timeout cycle still counts as a press.
        if (btn_rise != 3'b000) begin
          if (btn_single) begin
            pick_d  = btn_index(btn_rise);
            state_d = S_CHECK;
          end else begin
            state_d = S_LOSE;
          end
        end
`ifdef TIMEOUT_EN
        else if (timer_q == '0) begin
          state_d = S_LOSE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
`endif
      end
      S_CHECK: begin
        if (pick_q != cur_colour) begin
          state_d = S_LOSE;
        end else if (last_idx) begin
          state_d = (level_q == 4'(MAX_LEVEL)) ? S_WIN : S_ADD;
        end else begin
          seq_d   = seq_q + 4'd1;
`ifdef TIMEOUT_EN
          timer_d = TO_LOAD;
`endif
          state_d = S_WAIT_IN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Edge-detect history keeps tracking through reset so a held start is not a new edge.
  always_ff @(posedge clock) begin
    start_q <= start;
    btn_q   <= btn;
    if (mem_we) begin
      mem[level_q] <= lfsr_colour;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      level_q <= 4'd0;
      seq_q   <= 4'd0;
      timer_q <= '0;
      pick_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      seq_q   <= seq_d;
      timer_q <= timer_d;
      pick_q  <= pick_d;
    end
  end

  assign led_colour     = (state_q == S_SHOW_ON) ? onehot(cur_colour) : 3'b000;
  assign win            = (state_q == S_WIN);
  assign lose           = (state_q == S_LOSE);
  assign State          = state_q;
  assign Next_state     = state_d;
  assign Current_level  = level_q;
  assign Sequence_count = seq_q;
  assign Current_number = {2'b00, cur_colour};

endmodule

// File: tb/tb_genius_round_ctrl.sv
// Directed bench for genius_round_ctrl with short show/gap timings.
module tb_genius_round_ctrl;

  localparam int ST_IDLE = 0, ST_ADD = 1, ST_SHOW_ON = 2, ST_SHOW_OFF = 3;
  localparam int ST_WAIT_IN = 4, ST_CHECK = 5, ST_WIN = 6, ST_LOSE = 7;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b1;
  logic [2:0] btn   = 3'b000;
  logic [7:0] sw    = 8'h00;
  logic [2:0] led_colour;
  logic       win, lose;
  logic [2:0] State, Next_state;
  logic [3:0] Current_level, Sequence_count, Current_number;

  int tests_run = 0;
  int tests_failed = 0;

  genius_round_ctrl #(
    .MAX_LEVEL      (3),
    .SHOW_CYCLES    (2),
    .GAP_CYCLES     (1),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .btn            (btn),
    .sw             (sw),
    .led_colour     (led_colour),
    .win            (win),
    .lose           (lose),
    .State          (State),
    .Next_state     (Next_state),
    .Current_level  (Current_level),
    .Sequence_count (Sequence_count),
    .Current_number (Current_number)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic wait_state(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && int'(State) != target; i++) step();
    check_eq(tag, 32'(State), 32'(target));
  endtask

  // Single clean press: rising edge on one cycle, release on the next.
  task automatic press(input logic [2:0] b);
    btn = b;
    step();
    btn = 3'b000;
    step();
  endtask

  task automatic start_edge();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with start held high; no game without a fresh edge
    step(2);
    reset = 1'b0;
    step();
    check_eq("reset_state", 32'(State), ST_IDLE);
    check_eq("reset_led", 32'(led_colour), 0);
    check_eq("reset_level", 32'(Current_level), 0);
    check_eq("reset_winlose", 32'({win, lose}), 0);
    step(3);
    check_eq("held_start_idle", 32'(State), ST_IDLE);

    // 2: seed 0x01 -> sequence 1,2,0; precise level-1 timing
    sw = 8'h01;
    start = 1'b0;
    step();
    start = 1'b1;
    #1;
    check_eq("next_state_add", 32'(Next_state), ST_ADD);
    step();
    check_eq("add_state", 32'(State), ST_ADD);
    check_eq("add_led_dark", 32'(led_colour), 0);
    step();
    check_eq("l1_show_state", 32'(State), ST_SHOW_ON);
    check_eq("l1_led_c1", 32'(led_colour), 3'b010);
    check_eq("l1_level", 32'(Current_level), 1);
    check_eq("l1_number", 32'(Current_number), 1);
    step();
    check_eq("l1_led_c2", 32'(led_colour), 3'b010);
    step();
    check_eq("l1_show_off", 32'(State), ST_SHOW_OFF);
    check_eq("l1_gap_dark", 32'(led_colour), 0);
    step();
    check_eq("l1_wait_in", 32'(State), ST_WAIT_IN);

    // 3: correct play to WIN
    press(3'b010);
    check_eq("l1_to_add", 32'(State), ST_ADD);
    wait_state("l2_show0", ST_SHOW_ON, 10);
    check_eq("l2_led0", 32'(led_colour), 3'b010);
    wait_state("l2_gap0", ST_SHOW_OFF, 10);
    wait_state("l2_show1", ST_SHOW_ON, 10);
    check_eq("l2_led1", 32'(led_colour), 3'b100);
    check_eq("l2_seqcnt1", 32'(Sequence_count), 1);
    wait_state("l2_wait", ST_WAIT_IN, 10);
    check_eq("l2_level", 32'(Current_level), 2);
    press(3'b010);
    check_eq("l2_next_wait", 32'(State), ST_WAIT_IN);
    check_eq("l2_next_idx", 32'(Sequence_count), 1);
    press(3'b100);
    check_eq("l2_to_add", 32'(State), ST_ADD);
    wait_state("l3_wait", ST_WAIT_IN, 30);
    check_eq("l3_level", 32'(Current_level), 3);
    check_eq("l3_number0", 32'(Current_number), 1);
    press(3'b010);
    press(3'b100);
    check_eq("l3_number2", 32'(Current_number), 0);
    press(3'b001);
    check_eq("win_state", 32'(State), ST_WIN);
    check_eq("win_flags", 32'({win, lose}), 2'b10);

    // 4: wrong press at level 2 -> LOSE, then restart
    start_edge();
    check_eq("g2_add", 32'(State), ST_ADD);
    wait_state("g2_l1_wait", ST_WAIT_IN, 10);
    press(3'b010);
    wait_state("g2_l2_wait", ST_WAIT_IN, 20);
    press(3'b010);
    btn = 3'b001;
    step();
    check_eq("wrong_check", 32'(State), ST_CHECK);
    btn = 3'b000;
    step();
    check_eq("wrong_lose", 32'(State), ST_LOSE);
    check_eq("lose_flags", 32'({win, lose}), 2'b01);
    start_edge();
    check_eq("restart_add", 32'(State), ST_ADD);
    step();
    check_eq("restart_level", 32'(Current_level), 1);

    // 5: press during SHOW_ON ignored; two simultaneous edges lose
    check_eq("g3_show_on", 32'(State), ST_SHOW_ON);
    press(3'b001);
    wait_state("g3_wait", ST_WAIT_IN, 10);
    step();
    check_eq("show_press_ignored", 32'(State), ST_WAIT_IN);
    btn = 3'b011;
    step();
    check_eq("double_press_lose", 32'(State), ST_LOSE);
    btn = 3'b000;

    // 6: timeout behaviour, then reset mid-show
    start_edge();
    wait_state("g4_wait", ST_WAIT_IN, 10);
`ifdef TIMEOUT_EN
    step(19);
    check_eq("timeout_not_yet", 32'(State), ST_WAIT_IN);
    step();
    check_eq("timeout_lose", 32'(State), ST_LOSE);
`else
    step(100);
    check_eq("no_timeout_wait", 32'(State), ST_WAIT_IN);
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
    start_edge();
    wait_state("g5_show_on", ST_SHOW_ON, 5);
    reset = 1'b1;
    step();
    check_eq("midshow_reset_state", 32'(State), ST_IDLE);
    check_eq("midshow_reset_led", 32'(led_colour), 0);
    check_eq("midshow_reset_level", 32'(Current_level), 0);
    reset = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
